// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared MIPS definitions: ALU control, mul/div op and state codes
package muldiv_unit_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_NOR = 4'b0100,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b1001,
        ALU_SRA = 4'b1010
    } aluCtrl_t;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_FIX  = 2'b10;

    // MULT and DIV are the signed flavours (op[0] clear)
    function automatic logic isSignedOp(input logic [1:0] op);
        return !op[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - pipeline-side request/result bundle of the mul/div unit
interface muldiv_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             flush;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, srca, srcb, flush, mthi, mtlo, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, srca, srcb, flush, mthi, mtlo, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 shift-add / restoring-subtract iteration
module muldiv_step #(parameter int WIDTH = 32) (
    input  logic             isDiv,
    input  logic [WIDTH-1:0] accHi,
    input  logic [WIDTH-1:0] accLo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nextHi,
    output logic [WIDTH-1:0] nextLo
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             geq;

    // Multiply: add multiplicand on LSB of accLo, shift {carry,accHi,accLo} right.
    // Divide: shift {accHi,accLo} left one bit, keep the subtraction when it does not borrow.
    always_comb begin
        sum     = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
        shifted = {accHi, accLo[WIDTH-1]};
        geq     = (shifted >= {1'b0, operand});
        diff    = shifted[WIDTH-1:0] - operand;
        if (isDiv) begin
            nextHi = geq ? diff : shifted[WIDTH-1:0];
            nextLo = {accLo[WIDTH-2:0], geq};
        end else begin
            nextHi = sum[WIDTH:1];
            nextLo = {sum[0], accLo[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS HI/LO multiply/divide unit
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [1:0]         opReg;
    logic               signA;
    logic               signB;
    logic               divZero;
    logic [WIDTH-1:0]   dividendRaw;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   accHi;
    logic [WIDTH-1:0]   accLo;
    logic [WIDTH-1:0]   stepHi;
    logic [WIDTH-1:0]   stepLo;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic               busyReg;
    logic               doneReg;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic               negA;
    logic               negB;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   fixHi;
    logic [WIDTH-1:0]   fixLo;

    muldiv_step #(.WIDTH(WIDTH)) uStep (
        .isDiv   (opReg[1]),
        .accHi   (accHi),
        .accLo   (accLo),
        .operand (operand),
        .nextHi  (stepHi),
        .nextLo  (stepLo)
    );

    // Operand magnitudes for the iteration; unsigned ops pass straight through
    always_comb begin
        negA = isSignedOp(bus.op) & bus.srca[WIDTH-1];
        negB = isSignedOp(bus.op) & bus.srcb[WIDTH-1];
        absA = negA ? -bus.srca : bus.srca;
        absB = negB ? -bus.srcb : bus.srcb;
    end

    // Sign fix-up of the magnitude result; divide by zero returns the raw dividend
    always_comb begin
        fixHi   = accHi;
        fixLo   = accLo;
        product = {accHi, accLo};
        if (!opReg[1]) begin
            if (signA ^ signB) product = -product;
            fixHi = product[2*WIDTH-1:WIDTH];
            fixLo = product[WIDTH-1:0];
        end else if (divZero) begin
            fixHi = dividendRaw;
            fixLo = '1;
        end else begin
            if (signA ^ signB) fixLo = -accLo;
            if (signA) fixHi = -accHi;
        end
    end

    // Control FSM, iteration counter, accumulators and architectural HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            busyReg <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        opReg       <= bus.op;
                        signA       <= negA;
                        signB       <= negB;
                        divZero     <= (bus.srcb == '0);
                        dividendRaw <= bus.srca;
                        accHi       <= '0;
                        accLo       <= bus.op[1] ? absA : absB;
                        operand     <= bus.op[1] ? absB : absA;
                        count       <= CW'(WIDTH);
                        state       <= ST_RUN;
                        busyReg     <= 1'b1;
                    end else begin
                        if (bus.mthi) hiReg <= bus.wdata;
                        if (bus.mtlo) loReg <= bus.wdata;
                    end
                end
                ST_RUN: begin
                    if (bus.flush) begin
                        state   <= ST_IDLE;
                        busyReg <= 1'b0;
                    end else begin
                        accHi <= stepHi;
                        accLo <= stepLo;
                        count <= count - CW'(1);
                        if (count == CW'(1)) state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state   <= ST_IDLE;
                    busyReg <= 1'b0;
                    if (!bus.flush) begin
                        hiReg   <= fixHi;
                        loReg   <= fixLo;
                        doneReg <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi   = hiReg;
    assign bus.lo   = loReg;
    assign bus.busy = busyReg;
    assign bus.done = doneReg;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized and directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    logic clk;
    logic rst32;
    logic rst8;
    int   total;
    int   bad;
    logic [31:0] expHi;
    logic [31:0] expLo;

    muldiv_unit_if #(.WIDTH(32)) b32();
    muldiv_unit_if #(.WIDTH(8))  b8();

    muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst32), .bus(b32));
    muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Architectural result from plain integer arithmetic: returns {hi, lo}
    function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input int w);
        logic [63:0] mask;
        longint      sa, sb, ua, ub, q, r, p;
        logic [63:0] pu;
        logic [63:0] hiV, loV;
        mask = (64'd1 << w) - 64'd1;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = a[w-1] ? ua - (longint'(1) << w) : ua;
        sb = b[w-1] ? ub - (longint'(1) << w) : ub;
        case (op)
            2'b00: begin
                p   = sa * sb;
                hiV = 64'(p >>> w) & mask;
                loV = 64'(p) & mask;
            end
            2'b01: begin
                pu  = {32'b0, a} * {32'b0, b};
                hiV = (pu >> w) & mask;
                loV = pu & mask;
            end
            default: begin
                if (b == 32'b0) begin
                    hiV = {32'b0, a};
                    loV = mask;
                end else begin
                    if (op == 2'b10) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = ua / ub;
                        r = ua % ub;
                    end
                    hiV = 64'(r) & mask;
                    loV = 64'(q) & mask;
                end
            end
        endcase
        return {hiV[31:0], loV[31:0]};
    endfunction

    // One operation on the 32-bit unit; noise drives start/mthi/mtlo/operand junk while busy
    task automatic doOp32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit noise, input string tag);
        logic [63:0] res;
        int          n;
        int          busyCnt;
        bit          seen;
        res = refModel(op, a, b, 32);
        b32.op = op; b32.srca = a; b32.srcb = b; b32.start = 1'b1;
        @(posedge clk); #1;
        if (noise) begin
            b32.mthi = 1'b1; b32.mtlo = 1'b1; b32.wdata = $urandom;
            b32.srca = $urandom; b32.srcb = $urandom; b32.op = 2'($urandom);
        end else begin
            b32.start = 1'b0;
        end
        n = 1; busyCnt = 0; seen = 1'b0;
        while (!seen && n < 200) begin
            if (b32.done) seen = 1'b1;
            else begin
                if (b32.busy) busyCnt++;
                @(posedge clk); #1;
                n++;
            end
        end
        b32.start = 1'b0; b32.mthi = 1'b0; b32.mtlo = 1'b0;
        checkEq({tag, "_done"}, 64'(seen), 64'd1);
        checkEq({tag, "_lat"}, 64'(n), 64'd34);
        checkEq({tag, "_busycyc"}, 64'(busyCnt), 64'd33);
        checkEq({tag, "_hi"}, 64'(b32.hi), 64'(res[63:32]));
        checkEq({tag, "_lo"}, 64'(b32.lo), 64'(res[31:0]));
        expHi = res[63:32];
        expLo = res[31:0];
        @(posedge clk); #1;
        checkEq({tag, "_donepulse"}, 64'(b32.done), 64'd0);
    endtask

    initial begin
        int n;
        int doneCnt;
        bit seen;
        logic [31:0] ra, rb;
        logic [63:0] res8;
        total = 0; bad = 0;
        {b32.start, b32.op, b32.srca, b32.srcb, b32.flush, b32.mthi, b32.mtlo, b32.wdata} = '0;
        {b8.start, b8.op, b8.srca, b8.srcb, b8.flush, b8.mthi, b8.mtlo, b8.wdata} = '0;
        rst32 = 1'b1; rst8 = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checkEq("rst_hi", 64'(b32.hi), 64'd0);
        checkEq("rst_lo", 64'(b32.lo), 64'd0);
        checkEq("rst_busy", 64'(b32.busy), 64'd0);
        checkEq("rst_done", 64'(b32.done), 64'd0);
        expHi = '0; expLo = '0;

        // WIDTH=8: start presented together with reset release
        rst8 = 1'b0; rst32 = 1'b0;
        b8.op = 2'b00; b8.srca = 8'h80; b8.srcb = 8'h80; b8.start = 1'b1;
        res8 = refModel(2'b00, 32'h80, 32'h80, 8);
        @(posedge clk); #1;
        b8.start = 1'b0;
        n = 1; seen = 1'b0;
        while (!seen && n < 50) begin
            if (b8.done) seen = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        checkEq("w8_done", 64'(seen), 64'd1);
        checkEq("w8_lat", 64'(n), 64'd10);
        checkEq("w8_hi", 64'(b8.hi), 64'(res8[63:32]));
        checkEq("w8_lo", 64'(b8.lo), 64'(res8[31:0]));
        checkEq("w8_hi_const", 64'(b8.hi), 64'h40);

        doOp32(2'b00, 32'h00000007, 32'hFFFFFFFD, 1'b0, "mult_7_m3");
        checkEq("mult_7_m3_lo_const", 64'(b32.lo), 64'hFFFFFFEB);
        doOp32(2'b11, 32'd100, 32'd7, 1'b0, "divu_100_7");
        doOp32(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, "div_m7_2");
        doOp32(2'b11, 32'd5, 32'd0, 1'b0, "divu_by0");
        doOp32(2'b10, 32'h80000000, 32'd0, 1'b0, "div_neg_by0");
        doOp32(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");

        // Flush mid-RUN: hi/lo hold, no done
        b32.op = 2'b01; b32.srca = 32'hFFFFFFFF; b32.srcb = 32'hFFFFFFFF; b32.start = 1'b1;
        @(posedge clk); #1;
        b32.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        b32.flush = 1'b1;
        @(posedge clk); #1;
        b32.flush = 1'b0;
        checkEq("flush_busy", 64'(b32.busy), 64'd0);
        checkEq("flush_hi", 64'(b32.hi), 64'(expHi));
        checkEq("flush_lo", 64'(b32.lo), 64'(expLo));
        doneCnt = 0;
        repeat (40) begin
            if (b32.done) doneCnt++;
            @(posedge clk); #1;
        end
        checkEq("flush_nodone", 64'(doneCnt), 64'd0);
        doOp32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_after_flush");

        // flush + start together in IDLE: nothing starts
        b32.start = 1'b1; b32.flush = 1'b1;
        @(posedge clk); #1;
        b32.start = 1'b0; b32.flush = 1'b0;
        checkEq("flush_start_busy", 64'(b32.busy), 64'd0);

        // mthi in IDLE
        b32.mthi = 1'b1; b32.wdata = 32'h12345678;
        @(posedge clk); #1;
        b32.mthi = 1'b0;
        checkEq("mthi_hi", 64'(b32.hi), 64'h12345678);
        checkEq("mthi_lo", 64'(b32.lo), 64'(expLo));
        expHi = 32'h12345678;

        // mtlo/mthi and a second start hammered while busy are ignored
        doOp32(2'b11, 32'd100, 32'd7, 1'b1, "busy_noise");

        // Reset mid-RUN
        b32.op = 2'b00; b32.srca = 32'h1234; b32.srcb = 32'h5678; b32.start = 1'b1;
        @(posedge clk); #1;
        b32.start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst32 = 1'b1;
        @(posedge clk); #1;
        rst32 = 1'b0;
        checkEq("midrst_hi", 64'(b32.hi), 64'd0);
        checkEq("midrst_lo", 64'(b32.lo), 64'd0);
        checkEq("midrst_busy", 64'(b32.busy), 64'd0);
        expHi = '0; expLo = '0;

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'd1 + 32'($urandom_range(0, 15));
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
            doOp32(2'($urandom_range(0, 3)), ra, rb, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
